// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} arb_owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-stage request/response and memory-side signals of the shared port.
// master = requesters + memory array, slave = the arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_mem;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_valid, d_rdata, d_valid,
      input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_valid, d_rdata, d_valid,
      output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
   );
endinterface

// File: rtl/mem_arb_wait_cnt.sv
// Loadable down-counter timing one memory access; last flags the final cycle.
module mem_arb_wait_cnt
   import mem_arb_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [WAIT_CNT_W-1:0] loadVal,
   input  logic                  dec,
   output logic [WAIT_CNT_W-1:0] cnt,
   output logic                  last
);
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= loadVal;
      else if (dec && cnt != '0)
         cnt <= cnt - WAIT_CNT_W'(1);
   end

   assign last = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (IF) and data (MEM) stages.
// Define MEM_ARB_STARVE_GUARD_EN to bound consecutive data grants while a fetch waits.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int WAIT_STATES     = 1,
   parameter int MAX_DATA_STREAK = 4
) (
   input logic clk,
   input logic reset,
   mem_port_arbiter_if.slave bus
);
   arb_state_t            state, stateNext;
   arb_owner_t            owner;
   logic                  ownerWe;
   logic                  grantD, grantIf, grant;
   logic                  dWins;
   logic                  inAccess, accessLast;
   logic [WAIT_CNT_W-1:0] cnt;
   logic                  cntLast;

   logic                  memEn, memWe;
   logic [ADDR_W-1:0]     memAddr;
   logic [DATA_W-1:0]     memWdata, ifRdata, dRdata;
   logic                  ifValid, dValid;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [3:0] streak;
   logic       streakFull;

   assign streakFull = (streak == 4'(MAX_DATA_STREAK));
   assign dWins      = bus.d_req & ~(bus.if_req & streakFull);

   always_ff @(posedge clk) begin
      if (reset)
         streak <= '0;
      else if (state == IDLE) begin
         if (!bus.if_req || grantIf)
            streak <= '0;
         else if (grantD && !streakFull)
            streak <= streak + 4'd1;
      end
   end
`else
   logic [31:0] unusedStreakCfg;

   assign unusedStreakCfg = 32'(MAX_DATA_STREAK);
   assign dWins           = bus.d_req;
`endif

   assign grantD     = (state == IDLE) & dWins;
   assign grantIf    = (state == IDLE) & bus.if_req & ~dWins;
   assign grant      = grantD | grantIf;
   assign inAccess   = (state == ACCESS);
   assign accessLast = inAccess & cntLast;

   mem_arb_wait_cnt u_waitCnt (
      .clk     (clk),
      .reset   (reset),
      .load    (grant),
      .loadVal (WAIT_CNT_W'(WAIT_STATES)),
      .dec     (inAccess),
      .cnt     (cnt),
      .last    (cntLast)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (grant) stateNext = ACCESS;
         ACCESS:  if (cntLast) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Outputs are registered one cycle ahead: the strobe for the last ACCESS
   // cycle is set while the counter still reads 1 (or at grant if no waits).
   always_ff @(posedge clk) begin
      if (reset) begin
         owner    <= OWN_NONE;
         ownerWe  <= 1'b0;
         memEn    <= 1'b0;
         memWe    <= 1'b0;
         memAddr  <= '0;
         memWdata <= '0;
         ifRdata  <= '0;
         dRdata   <= '0;
         ifValid  <= 1'b0;
         dValid   <= 1'b0;
      end else begin
         memEn   <= grant | (inAccess & ~cntLast);
         memWe   <= (grantD & bus.d_we & (WAIT_STATES == 0)) |
                    (inAccess & ownerWe & (cnt == WAIT_CNT_W'(1)));
         ifValid <= accessLast & (owner == OWN_IF);
         dValid  <= accessLast & (owner == OWN_D);
         if (grant) begin
            owner   <= grantD ? OWN_D : OWN_IF;
            ownerWe <= grantD & bus.d_we;
            memAddr <= grantD ? bus.d_addr : bus.if_addr;
            if (grantD)
               memWdata <= bus.d_wdata;
         end
         if (accessLast) begin
            if (owner == OWN_IF)
               ifRdata <= bus.mem_rdata;
            else if (owner == OWN_D && !ownerWe)
               dRdata <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_en    = memEn;
   assign bus.mem_we    = memWe;
   assign bus.mem_addr  = memAddr;
   assign bus.mem_wdata = memWdata;
   assign bus.if_rdata  = ifRdata;
   assign bus.d_rdata   = dRdata;
   assign bus.if_valid  = ifValid;
   assign bus.d_valid   = dValid;
   assign bus.stall_if  = bus.if_req & ~ifValid;
   assign bus.stall_mem = bus.d_req & ~dValid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand sequences.
// Expectations for the starvation case follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   nChecks = 0;
   int   nFail   = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .WAIT_STATES(1), .MAX_DATA_STREAK(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ifReq;
      logic [31:0] ifAddr;
      logic        dReq;
      logic        dWe;
      logic [31:0] dAddr;
      logic [31:0] dWdata;
      logic [31:0] memRdata;
      logic        expEn;
      logic        expWe;
      logic [31:0] expAddr;
      logic [31:0] expWdata;
      logic        expIfV;
      logic        expDV;
      logic        expStIf;
      logic        expStMem;
      logic [31:0] expIfR;
      logic [31:0] expDR;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ifReq, input logic [31:0] ifAddr, input logic dReq,
                        input logic dWe, input logic [31:0] dAddr, input logic [31:0] dWdata,
                        input logic [31:0] memRdata);
      bus.if_req    = ifReq;
      bus.if_addr   = ifAddr;
      bus.d_req     = dReq;
      bus.d_we      = dWe;
      bus.d_addr    = dAddr;
      bus.d_wdata   = dWdata;
      bus.mem_rdata = memRdata;
   endtask

   initial begin
      int dvAt, ivAt, dvCnt, ivCnt, stallErr, weCnt;
      int ivFirst, ivSecond;

      vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
      vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
      vecs[2]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0, 32'h20080005, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
      vecs[3]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20080005, 32'h0};
      vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20080005, 32'h0};
      vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h60, 32'h0, 32'h0,        1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'h0};
      vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h60, 32'h0, 32'h0,        1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'h0};
      vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h60, 32'h0, 32'hCAFE0001, 1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'h0};
      vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h60, 32'h0, 32'h0,        1'b0, 1'b0, 32'h60, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20080005, 32'hCAFE0001};
      vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h54, 32'h7, 32'h0,        1'b0, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'hCAFE0001};
      vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h54, 32'h7, 32'h0,        1'b1, 1'b0, 32'h54, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'hCAFE0001};
      vecs[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h54, 32'h7, 32'hDEADBEEF, 1'b1, 1'b1, 32'h54, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'hCAFE0001};
      vecs[12] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h54, 32'h7, 32'h0,        1'b0, 1'b0, 32'h54, 32'h7, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20080005, 32'hCAFE0001};
      vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0, 32'h0,        1'b0, 1'b0, 32'h54, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20080005, 32'hCAFE0001};

      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_outs", {30'b0, bus.mem_en, bus.mem_we}, 32'h0);
      chk("rst_addr", bus.mem_addr | bus.mem_wdata | bus.if_rdata | bus.d_rdata, 32'h0);
      chk("rst_valid", {30'b0, bus.if_valid, bus.d_valid}, 32'h0);

      // single fetch, load, store: one row per clock cycle
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         drive(vecs[i].ifReq, vecs[i].ifAddr, vecs[i].dReq, vecs[i].dWe,
               vecs[i].dAddr, vecs[i].dWdata, vecs[i].memRdata);
         @(negedge clk);
         chk($sformatf("v%0d mem_en", i),    32'(bus.mem_en),    32'(vecs[i].expEn));
         chk($sformatf("v%0d mem_we", i),    32'(bus.mem_we),    32'(vecs[i].expWe));
         chk($sformatf("v%0d mem_addr", i),  bus.mem_addr,       vecs[i].expAddr);
         chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata,      vecs[i].expWdata);
         chk($sformatf("v%0d if_valid", i),  32'(bus.if_valid),  32'(vecs[i].expIfV));
         chk($sformatf("v%0d d_valid", i),   32'(bus.d_valid),   32'(vecs[i].expDV));
         chk($sformatf("v%0d stall_if", i),  32'(bus.stall_if),  32'(vecs[i].expStIf));
         chk($sformatf("v%0d stall_mem", i), 32'(bus.stall_mem), 32'(vecs[i].expStMem));
         chk($sformatf("v%0d if_rdata", i),  bus.if_rdata,       vecs[i].expIfR);
         chk($sformatf("v%0d d_rdata", i),   bus.d_rdata,        vecs[i].expDR);
      end

      // simultaneous requests: data first, fetch regranted at the next IDLE
      dvAt = -1; ivAt = -1; dvCnt = 0; ivCnt = 0; stallErr = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         drive(c <= 7, 32'h80, c <= 3, 1'b0, 32'h90, 32'h0,
               (c == 2) ? 32'h11112222 : ((c == 6) ? 32'h33334444 : 32'h0));
         @(negedge clk);
         if (bus.d_valid) begin dvCnt++; if (dvAt < 0) dvAt = c; end
         if (bus.if_valid) begin ivCnt++; if (ivAt < 0) ivAt = c; end
         if (c <= 6 && !bus.stall_if) stallErr++;
         if (c == 5) chk("sim mem_addr_if", bus.mem_addr, 32'h80);
         if (c == 3) chk("sim d_rdata", bus.d_rdata, 32'h11112222);
         if (c == 7) chk("sim if_rdata", bus.if_rdata, 32'h33334444);
      end
      chk("sim d_valid_cycle", dvAt, 3);
      chk("sim if_valid_cycle", ivAt, 7);
      chk("sim valid_pulses", dvCnt + ivCnt, 2);
      chk("sim stall_if_held", stallErr, 0);

      // fetch held against a continuously re-asserted data request
      ivFirst = -1; ivSecond = -1; dvCnt = 0; ivCnt = 0; stallErr = 0;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         drive(1'b1, 32'hA0, 1'b1, 1'b0, 32'hB0, 32'h0, 32'h0);
         @(negedge clk);
         if (bus.d_valid) dvCnt++;
         if (bus.if_valid) begin
            ivCnt++;
            if (ivFirst < 0) ivFirst = c; else if (ivSecond < 0) ivSecond = c;
         end
         if (!bus.stall_if && !bus.if_valid) stallErr++;
      end
      @(posedge clk); #1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk("starve if_valid_count", ivCnt, 2);
      chk("starve first_if_valid", ivFirst, 11);
      chk("starve second_if_valid", ivSecond, 23);
      chk("starve d_valid_count", dvCnt, 4);
`else
      chk("strict if_valid_count", ivCnt, 0);
      chk("strict d_valid_count", dvCnt, 6);
      chk("strict first_if_valid", ivFirst, -1);
`endif
      chk("starve stall_if_held", stallErr, 0);
      repeat (3) @(posedge clk);

      // reset while a store is in its first ACCESS cycle
      weCnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         reset = (c == 1);
         if (c <= 1) drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h54, 32'h99, 32'h0);
         else        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
         @(negedge clk);
         if (bus.mem_we) weCnt++;
         if (c == 1) chk("rstmid in_access", 32'(bus.mem_en), 32'h1);
         if (c == 2) begin
            chk("rstmid ctl", {28'b0, bus.mem_en, bus.mem_we, bus.if_valid, bus.d_valid}, 32'h0);
            chk("rstmid data", bus.mem_addr | bus.mem_wdata | bus.if_rdata | bus.d_rdata, 32'h0);
            chk("rstmid state", 32'(dut.state), 32'(IDLE));
         end
         if (c == 4) chk("rstmid no_restart", 32'(bus.mem_en), 32'h0);
      end
      chk("rstmid mem_we_never", weCnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified instruction/data memory between the pipelined MIPS CPU's fetch stage (IF) and memory stage (MEM). Arbitrates and sequences each access through a fixed multi-cycle memory timing. Returns read data to the winning requester with a one-cycle valid pulse. Generates the per-stage stall signals that the hazard unit ORs into stallF/stallD and the EX/MEM hold.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_STATES, 1, extra memory cycles per access; legal range 0..15
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch waits; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle completion pulse
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle completion pulse
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- stall_if  out  1  if_req & ~if_valid (combinational)
- stall_mem  out  1  d_req & ~d_valid (combinational)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: arbitrate on the current requests.
  - d_req wins unless if_req is pending and streak == MAX_DATA_STREAK.
  - Otherwise if_req wins.
  - On a grant, latch owner, addr, we and wdata, then go to ACCESS with the wait counter at WAIT_STATES.
  - No request: stay in IDLE.
- ACCESS: mem_en=1 and mem_addr = latched address.
  - Counter decrements each cycle; the last cycle is counter == 0.
  - mem_we=1 only in the last cycle, and only for a data store.
  - Last cycle: capture mem_rdata into the owner's rdata register (loads and fetches only), then go to DONE.
- DONE: owner's valid=1 for exactly one cycle, then go to IDLE.
  - Never re-arbitrates in DONE. The requester's req still reflects the completed access.
- Streak counter (width 4):
  - increments on a data grant while if_req is high;
  - clears on an IF grant or whenever if_req is low in IDLE;
  - saturates at MAX_DATA_STREAK.
- if_rdata/d_rdata hold their last captured value until the next capture of the same port. A store does not alter d_rdata.
- Dropping a request before its valid is illegal. The arbiter completes the access anyway and pulses valid.
- Reset applies in any state:
  - state goes to IDLE; counter, streak and owner clear;
  - all outputs go to 0 (mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_valid, d_valid);
  - an in-flight store whose strobe has not yet issued is dropped.

## Timing
- The request is sampled in IDLE at cycle 0. ACCESS occupies cycles 1..WAIT_STATES+1, and valid is high in cycle WAIT_STATES+2.
- Total service time is WAIT_STATES+3 cycles per access; for WAIT_STATES=1, valid arrives 3 cycles after the request.
- In the valid cycle, stall drops, so the pipeline register captures rdata on that same edge.
- If both requests arrive simultaneously in IDLE, data wins, subject to the starvation guard.
- The loser stays stalled. It is granted at the IDLE after DONE: the earliest regrant cycle is WAIT_STATES+3.
- All memory-side outputs are registered. Only stall_if and stall_mem are combinational.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: the streak counter and the MAX_DATA_STREAK rule are active.
- Undefined: strict data priority, and the streak logic is not compiled. MAX_DATA_STREAK is then ignored.

## Structure
- Package mem_arb_pkg:
  - arb_state_t enum (IDLE, ACCESS, DONE);
  - arb_owner_t enum (OWN_NONE, OWN_IF, OWN_D);
  - WAIT_CNT_W=4 constant.
- Sub-module mem_arb_wait_cnt: loadable down-counter with a `last` flag, instantiated once for the ACCESS duration.

## Test plan
- Single fetch: WAIT_STATES=1, if_req with if_addr=0x40, mem_rdata=0x20080005 -> mem_en in cycles 1–2, if_valid only in cycle 3, if_rdata=0x20080005, stall_if high in cycles 0–2.
- Store: d_we=1, d_addr=0x54, d_wdata=0x7 -> mem_we high only in cycle 2, mem_addr=0x54, mem_wdata=0x7, d_valid in cycle 3, d_rdata unchanged.
- Simultaneous requests: if_req+d_req in cycle 0 -> data served first with d_valid in cycle 3; IF granted in cycle 4 with if_valid in cycle 7.
- Starvation, MEM_ARB_STARVE_GUARD_EN with MAX_DATA_STREAK=2: if_req held while d_req is continuously re-asserted -> two data accesses, then the IF access, then the streak clears.
- Same stimulus without the macro -> IF is never granted while d_req stays high.
- Reset mid-store in cycle 1 -> mem_we never asserts, all outputs are 0 next cycle, and the FSM is in IDLE.
